// File: rtl/vred_seq_pkg.sv
// Shared definitions for the vector reduction sequencer: op/SEW codes, FSM
// state encoding and the per-op identity element.
package vred_seq_pkg;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpAnd  = 2'b01,
        OpOr   = 2'b10,
        OpXor  = 2'b11
    } vred_op_e;

    typedef enum logic [1:0] {
        Sew8  = 2'b00,
        Sew16 = 2'b01,
        Sew32 = 2'b10,
        Sew64 = 2'b11
    } vred_sew_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StDrain = 2'b10
    } vred_state_e;

    // Identity byte: AND needs all-ones so padding never clears a result bit,
    // OR/XOR need zero so padding never sets one.
    function automatic logic [7:0] identity_byte(input logic [1:0] op_sel);
        return (op_sel == OpAnd) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/vred_tail_mask.sv
// Replaces elements at or beyond the valid-element count with the op identity.
module vred_tail_mask
    import vred_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            sew,
    input  logic [3:0]            valid_cnt,
    input  logic [1:0]            op_sel,
    output logic [DATA_WIDTH-1:0] masked
);

    // Byte b belongs to element b >> sew; keep it only if that element is valid.
    always_comb begin
        masked = '0;
        for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
            if ((b >> sew) < int'(valid_cnt)) begin
                masked[b*8 +: 8] = data[b*8 +: 8];
            end else begin
                masked[b*8 +: 8] = identity_byte(op_sel);
            end
        end
    end

endmodule

// File: rtl/vred_seq.sv
// Vector reduction sequencer: reads the source vector beat by beat from the
// register file, tail-masks the last beat and feeds the reducer.
module vred_seq
    import vred_seq_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH = 32,
    parameter int unsigned VRF_ADDR_WIDTH = 8,
    parameter int unsigned VL_WIDTH       = 12,
    parameter int unsigned OPSEL_WIDTH    = 2,
    parameter int unsigned SEW_WIDTH      = 2,
    parameter bit          ENABLE_64_BIT  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [OPSEL_WIDTH-1:0]    req_opSel,
    input  logic [SEW_WIDTH-1:0]      req_sew,
    input  logic [VL_WIDTH-1:0]       req_vl,
    input  logic [VRF_ADDR_WIDTH-1:0] req_vs2,
    input  logic [REQ_DATA_WIDTH-1:0] req_scalar,
    input  logic [REQ_ADDR_WIDTH-1:0] req_addr,
    output logic                      req_err,
    output logic                      rd_en,
    output logic [VRF_ADDR_WIDTH-1:0] rd_addr,
    input  logic [REQ_DATA_WIDTH-1:0] rd_data,
    output logic [REQ_DATA_WIDTH-1:0] out_vec0,
    output logic [REQ_DATA_WIDTH-1:0] out_vec1,
    output logic                      out_valid,
    output logic                      out_start,
    output logic                      out_end,
    output logic [OPSEL_WIDTH-1:0]    out_opSel,
    output logic [SEW_WIDTH-1:0]      out_sew,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr
);

    vred_state_e state_q, state_d;

    // Latched request
    logic [OPSEL_WIDTH-1:0]    op_q;
    logic [SEW_WIDTH-1:0]      sew_q;
    logic [VRF_ADDR_WIDTH-1:0] vs2_q;
    logic [REQ_DATA_WIDTH-1:0] scalar_q;
    logic [REQ_ADDR_WIDTH-1:0] addr_q;

    // Beat index issued so far and elements still to be issued
    logic [VL_WIDTH-1:0] beat_q;
    logic [VL_WIDTH-1:0] rem_q;

    // Read-data stage: describes the beat whose rd_data is arriving this cycle
    logic       s1_valid_q;
    logic       s1_start_q;
    logic       s1_end_q;
    logic [3:0] s1_cnt_q;

    logic [REQ_DATA_WIDTH-1:0] out_vec0_q, out_vec1_q;
    logic                      out_valid_q, out_start_q, out_end_q;
    logic [OPSEL_WIDTH-1:0]    out_op_q;
    logic [SEW_WIDTH-1:0]      out_sew_q;
    logic [REQ_ADDR_WIDTH-1:0] out_addr_q;
    logic                      err_q;

    logic                      accept, illegal, issue, is_last;
    logic [VL_WIDTH-1:0]       epb;
    logic [3:0]                beat_cnt;
    logic [REQ_DATA_WIDTH-1:0] masked;

    assign accept  = req_valid && (state_q == StIdle);
    assign illegal = (req_opSel == OpNone) || ((req_sew == Sew64) && !ENABLE_64_BIT);
    assign issue   = (state_q == StIssue);

    // Elements per beat; the last beat is the one that covers all remaining
    // elements, which also makes vl=0 a single all-identity beat.
    assign epb      = VL_WIDTH'(8) >> sew_q;
    assign is_last  = (rem_q <= epb);
    assign beat_cnt = is_last ? rem_q[3:0] : epb[3:0];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && !illegal) state_d = StIssue;
            StIssue: if (is_last) state_d = StDrain;
            StDrain: if (out_valid_q && out_end_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Request latch on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            sew_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= '0;
            addr_q   <= '0;
        end else if (accept) begin
            op_q     <= req_opSel;
            sew_q    <= req_sew;
            vs2_q    <= req_vs2;
            scalar_q <= req_scalar;
            addr_q   <= req_addr;
        end
    end

    // Beat and element counters
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            beat_q <= '0;
            rem_q  <= req_vl;
        end else if (issue) begin
            beat_q <= beat_q + 1'b1;
            rem_q  <= rem_q - VL_WIDTH'(beat_cnt);
        end
    end

    // Track each issued read until its data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_start_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_cnt_q   <= '0;
        end else begin
            s1_valid_q <= issue;
            s1_start_q <= issue && (beat_q == '0);
            s1_end_q   <= issue && is_last;
            s1_cnt_q   <= issue ? beat_cnt : 4'd0;
        end
    end

    vred_tail_mask #(
        .DATA_WIDTH (REQ_DATA_WIDTH)
    ) u_tail_mask (
        .data      (rd_data),
        .sew       (sew_q),
        .valid_cnt (s1_cnt_q),
        .op_sel    (op_q),
        .masked    (masked)
    );

    // Output register; side fields are zero whenever no beat is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_vec0_q  <= '0;
            out_vec1_q  <= '0;
            out_op_q    <= '0;
            out_sew_q   <= '0;
            out_addr_q  <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_start_q <= s1_start_q;
            out_end_q   <= s1_end_q;
            out_vec0_q  <= s1_valid_q ? masked   : '0;
            out_vec1_q  <= s1_valid_q ? scalar_q : '0;
            out_op_q    <= s1_valid_q ? op_q     : '0;
            out_sew_q   <= s1_valid_q ? sew_q    : '0;
            out_addr_q  <= s1_valid_q ? addr_q   : '0;
        end
    end

    // One-cycle error pulse for an accepted illegal request
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && illegal;
    end

    // Outputs are forced low while rst is held, including the first reset cycle
    assign req_ready = (state_q == StIdle) && !rst;
    assign req_err   = err_q && !rst;
    assign rd_en     = issue && !rst;
    assign rd_addr   = rd_en ? (vs2_q + VRF_ADDR_WIDTH'(beat_q)) : '0;
    assign out_valid = out_valid_q && !rst;
    assign out_start = out_start_q && !rst;
    assign out_end   = out_end_q && !rst;
    assign out_vec0  = rst ? '0 : out_vec0_q;
    assign out_vec1  = rst ? '0 : out_vec1_q;
    assign out_opSel = rst ? '0 : out_op_q;
    assign out_sew   = rst ? '0 : out_sew_q;
    assign out_addr  = rst ? '0 : out_addr_q;

endmodule

// File: tb/tb_vred_seq.sv
// Scoreboard bench for vred_seq.
module tb_vred_seq;

    typedef struct packed {
        logic [63:0] vec0;
        logic [63:0] vec1;
        logic        start;
        logic        last;
        logic [1:0]  op;
        logic [1:0]  sew;
        logic [31:0] addr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, n_req_valid;
    logic [1:0]  req_opSel, req_sew;
    logic [11:0] req_vl;
    logic [7:0]  req_vs2;
    logic [63:0] req_scalar;
    logic [31:0] req_addr;
    logic [63:0] rd_data;

    logic        req_ready, req_err, rd_en, out_valid, out_start, out_end;
    logic [7:0]  rd_addr;
    logic [63:0] out_vec0, out_vec1;
    logic [1:0]  out_opSel, out_sew;
    logic [31:0] out_addr;

    logic        n_req_ready, n_req_err, n_rd_en, n_out_valid, n_out_start, n_out_end;
    logic [7:0]  n_rd_addr;
    logic [63:0] n_out_vec0, n_out_vec1;
    logic [1:0]  n_out_opSel, n_out_sew;
    logic [31:0] n_out_addr;

    logic [63:0] mem [256];
    beat_t       exp_q[$];
    logic [7:0]  rd_q[$];
    beat_t       e_m;
    logic [7:0]  a_m;
    int          cyc = 0;
    int          n_vectors = 0;
    int          n_miscompares = 0;

    always #5 clk = ~clk;

    vred_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opSel(req_opSel),
        .req_sew(req_sew), .req_vl(req_vl), .req_vs2(req_vs2), .req_scalar(req_scalar),
        .req_addr(req_addr), .req_err(req_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_vec0(out_vec0), .out_vec1(out_vec1), .out_valid(out_valid),
        .out_start(out_start), .out_end(out_end), .out_opSel(out_opSel),
        .out_sew(out_sew), .out_addr(out_addr)
    );

    vred_seq #(.ENABLE_64_BIT(1'b0)) dut_n64 (
        .clk(clk), .rst(rst),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_opSel(req_opSel),
        .req_sew(req_sew), .req_vl(req_vl), .req_vs2(req_vs2), .req_scalar(req_scalar),
        .req_addr(req_addr), .req_err(n_req_err),
        .rd_en(n_rd_en), .rd_addr(n_rd_addr), .rd_data(rd_data),
        .out_vec0(n_out_vec0), .out_vec1(n_out_vec1), .out_valid(n_out_valid),
        .out_start(n_out_start), .out_end(n_out_end), .out_opSel(n_out_opSel),
        .out_sew(n_out_sew), .out_addr(n_out_addr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: data one cycle after the read strobe, junk otherwise
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_beat(input logic [1:0] op, input logic [1:0] sew,
                                               input int vl, input int k, input logic [63:0] d);
        logic [63:0] r;
        int epb, esz, elem;
        epb = 8 >> sew;
        esz = 1 << sew;
        for (int b = 0; b < 8; b++) begin
            elem = k * epb + b / esz;
            r[b*8 +: 8] = (elem < vl) ? d[b*8 +: 8] : ((op == 2'b01) ? 8'hFF : 8'h00);
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of T+1 with t_acc = accept cycle.
    task automatic send(input logic [1:0] op, input logic [1:0] sew, input int vl,
                        input logic [7:0] vs2, input logic [63:0] scalar,
                        input logic [31:0] addr, output int t_acc);
        int guard, epb, n;
        beat_t e;
        logic [7:0] ad;
        guard = 0;
        t_acc = -1;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_opSel = op; req_sew = sew; req_vl = 12'(vl); req_vs2 = vs2;
        req_scalar = scalar; req_addr = addr; req_valid = 1'b1;
        if (op != 2'b00) begin
            epb = 8 >> sew;
            n = (vl == 0) ? 1 : (vl + epb - 1) / epb;
            for (int k = 0; k < n; k++) begin
                ad = vs2 + 8'(k);
                e.vec0 = model_beat(op, sew, vl, k, mem[ad]);
                e.vec1 = scalar; e.start = (k == 0); e.last = (k == n - 1);
                e.op = op; e.sew = sew; e.addr = addr;
                exp_q.push_back(e);
                rd_q.push_back(ad);
            end
        end
        @(negedge clk);
        t_acc = cyc;
        req_valid = 1'b0;
    endtask

    // Monitor: compare every read strobe and every output beat against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    a_m = rd_q.pop_front();
                    check("rd_addr", 64'(rd_addr), 64'(a_m));
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    e_m = exp_q.pop_front();
                    check("out_vec0", out_vec0, e_m.vec0);
                    check("out_vec1", out_vec1, e_m.vec1);
                    check("out_flags", 64'({out_start, out_end, out_opSel, out_sew}),
                          64'({e_m.start, e_m.last, e_m.op, e_m.sew}));
                    check("out_addr", 64'(out_addr), 64'(e_m.addr));
                end
            end else begin
                check("out_idle_zero", out_vec0 | out_vec1 | 64'(out_addr) |
                      64'({out_start, out_end, out_opSel, out_sew}), 0);
            end
        end
        if (n_rd_en || n_out_valid) check("n64_quiet", 64'({n_rd_en, n_out_valid}), 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int t, ta, tb, guard;
        rst = 1'b1; req_valid = 1'b0; n_req_valid = 1'b0;
        req_opSel = '0; req_sew = '0; req_vl = '0; req_vs2 = '0; req_scalar = '0; req_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = {8{8'(i)}} ^ 64'h0F1E_2D3C_4B5A_6978;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 0);
        check("rst_rd_en", 64'(rd_en), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_err", 64'(req_err), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 1);

        // Tail masking, AND over bytes, vl=11
        mem[8'h10] = '0; mem[8'h11] = '0;
        send(2'b01, 2'b00, 11, 8'h10, 64'h55, 32'h1000, t);

        // Single 64-bit beat with timing
        mem[8'h20] = 64'h1234;
        send(2'b11, 2'b11, 1, 8'h20, 64'h77, 32'h2000, t);
        check("t026_rd_en", 64'(rd_en), 1);
        @(negedge clk); @(negedge clk);
        check("t026_out_valid_t3", 64'(out_valid), 1);
        @(negedge clk);
        check("t026_ready_t4", 64'(req_ready), 1);

        // Empty request: read data must be ignored
        mem[8'h30] = 64'hFFFF_0000_FFFF_0000;
        send(2'b10, 2'b00, 0, 8'h30, 64'hA5, 32'h3000, t);

        // Illegal opSel=00
        send(2'b00, 2'b01, 4, 8'h40, 64'h1, 32'h4000, t);
        check("t028_err_t1", 64'(req_err), 1);
        @(negedge clk);
        check("t028_err_t2", 64'(req_err), 0);
        check("t028_ready_t2", 64'(req_ready), 1);

        // Illegal sew=11 on the 64-bit-disabled instance
        req_opSel = 2'b11; req_sew = 2'b11; req_vl = 12'd1; n_req_valid = 1'b1;
        @(negedge clk);
        n_req_valid = 1'b0;
        check("t028n_err_t1", 64'(n_req_err), 1);
        @(negedge clk);
        check("t028n_err_t2", 64'(n_req_err), 0);
        check("t028n_ready_t2", 64'(n_req_ready), 1);

        // Wrap, ignored busy request, back-to-back acceptance
        send(2'b01, 2'b10, 8, 8'hFE, 64'hC3, 32'h5000, ta);
        req_opSel = 2'b10; req_sew = 2'b00; req_vl = 12'd5; req_vs2 = 8'h40; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        send(2'b10, 2'b01, 5, 8'h50, 64'h3C, 32'h6000, tb);
        check("t029_b2b_gap", 64'(tb - ta), 7);

        // Mixed requests, back to back
        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(3, 1)), 2'($urandom_range(3, 0)), $urandom_range(40, 0),
                 8'($urandom_range(255, 0)), {$urandom, $urandom}, $urandom, t);
        end

        // Mid-operation reset during beat 2 of 4
        send(2'b11, 2'b10, 8, 8'h60, 64'h99, 32'h7000, t);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        check("t030_rd_drained", 64'(rd_q.size()), 0);
        @(negedge clk);
        check("t030_out_valid", 64'(out_valid), 0);
        check("t030_rd_en", 64'(rd_en), 0);
        check("t030_ready_in_rst", 64'(req_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t030_ready_after", 64'(req_ready), 1);
        repeat (10) @(negedge clk);

        // Drain the scoreboard
        guard = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("sb_empty_beats", 64'(exp_q.size()), 0);
        check("sb_empty_reads", 64'(rd_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
